// File: rtl/fop_alu_seq.sv
// Sequential flag-producing ALU: single-cycle ops plus bit-serial shifts, one
// command in flight, valid/ready on both sides and a live flag register.
module fop_alu_seq #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              cmd,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out,
    output logic [WIDTH-1:0]        flags
);

    localparam int unsigned MSB   = WIDTH - 1;
    localparam int unsigned F_C   = 8;
    localparam int unsigned F_N   = 9;
    localparam int unsigned F_V   = 10;
    localparam int unsigned F_Z   = 11;
    localparam int unsigned F_ULE = 16;
    localparam int unsigned F_SLT = 17;
    localparam int unsigned F_SLE = 18;

    localparam logic [4:0] OP_ZERO     = 5'b00000;
    localparam logic [4:0] OP_SIGN     = 5'b00001;
    localparam logic [4:0] OP_PASSFLAG = 5'b00010;
    localparam logic [4:0] OP_LOADFLAG = 5'b00011;
    localparam logic [4:0] OP_INV      = 5'b00100;
    localparam logic [4:0] OP_ADD      = 5'b00101;
    localparam logic [4:0] OP_SUB      = 5'b00110;
    localparam logic [4:0] OP_AND      = 5'b00111;
    localparam logic [4:0] OP_OR       = 5'b01000;
    localparam logic [4:0] OP_XOR      = 5'b01001;
    localparam logic [4:0] OP_SHL      = 5'b01010;
    localparam logic [4:0] OP_SHR      = 5'b01011;
    localparam logic [4:0] OP_SAR      = 5'b01100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [4:0]         op_q, op_d;

    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     diff_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic [WIDTH-1:0]   step_c;
    logic               bit_c;
    logic               upd_nz_c;
    logic               accept_c;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept_c  = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out       = out_q;
    assign flags     = f_q;

    // One bit of the shift in flight and the bit it pushes out
    always_comb begin
        step_c = sh_q;
        bit_c  = 1'b0;
        case (op_q)
            OP_SHL: begin
                step_c = {sh_q[MSB-1:0], 1'b0};
                bit_c  = sh_q[MSB];
            end
            OP_SHR: begin
                step_c = {1'b0, sh_q[MSB:1]};
                bit_c  = sh_q[0];
            end
            OP_SAR: begin
                step_c = {sh_q[MSB], sh_q[MSB:1]};
                bit_c  = sh_q[0];
            end
            default: begin
                step_c = sh_q;
                bit_c  = 1'b0;
            end
        endcase
    end

    // Next-state, result and flag update
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        f_d      = f_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        upd_nz_c = 1'b0;
        sum_c    = {1'b0, a} + {1'b0, b};
        diff_c   = {1'b0, a} - {1'b0, b};
        shamt_c  = b[SHAMT_W-1:0];

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = HOLD;
                    case (cmd)
                        OP_ZERO: begin
                            out_d    = '0;
                            upd_nz_c = 1'b1;
                        end
                        OP_SIGN: begin
                            out_d    = {WIDTH{b[MSB]}};
                            upd_nz_c = 1'b1;
                        end
                        OP_PASSFLAG: out_d = f_q;
                        OP_LOADFLAG: begin
                            out_d = a;
                            f_d   = a;
                        end
                        OP_INV: begin
                            out_d    = ~a;
                            upd_nz_c = 1'b1;
                        end
                        OP_ADD: begin
                            out_d    = sum_c[MSB:0];
                            f_d[F_C] = sum_c[WIDTH];
                            f_d[F_V] = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);
                            upd_nz_c = 1'b1;
                        end
                        OP_SUB: begin
                            out_d      = diff_c[MSB:0];
                            f_d[F_C]   = !diff_c[WIDTH];
                            f_d[F_V]   = (a[MSB] != b[MSB]) && (diff_c[MSB] != a[MSB]);
                            f_d[F_ULE] = (a <= b);
                            f_d[F_SLT] = ($signed(a) < $signed(b));
                            f_d[F_SLE] = ($signed(a) <= $signed(b));
                            upd_nz_c   = 1'b1;
                        end
                        OP_AND: begin
                            out_d    = a & b;
                            upd_nz_c = 1'b1;
                        end
                        OP_OR: begin
                            out_d    = a | b;
                            upd_nz_c = 1'b1;
                        end
                        OP_XOR: begin
                            out_d    = a ^ b;
                            upd_nz_c = 1'b1;
                        end
                        OP_SHL, OP_SHR, OP_SAR: begin
                            // Zero-length shift completes like a single-cycle op
                            if (shamt_c == '0) begin
                                out_d = a;
                            end else begin
                                state_d = SHIFT;
                                sh_d    = a;
                                cnt_d   = shamt_c;
                                op_d    = cmd;
                            end
                        end
                        default: out_d = '0;
                    endcase
                end
            end
            SHIFT: begin
                sh_d  = step_c;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d  = HOLD;
                    out_d    = step_c;
                    f_d[F_C] = bit_c;
                    upd_nz_c = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (upd_nz_c) begin
            f_d[F_N] = out_d[MSB];
            f_d[F_Z] = (out_d == '0);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            f_q   <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
            op_q  <= '0;
        end else begin
            out_q <= out_d;
            f_q   <= f_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end

endmodule

// File: tb/tb_fop_alu_seq.sv
// Directed bench for fop_alu_seq (WIDTH=64): hand-computed results, flags,
// latencies, backpressure and reset behaviour.
module tb_fop_alu_seq;

    localparam logic [4:0] ZERO = 5'b00000, SIGN = 5'b00001, PASSF = 5'b00010,
                           LOADF = 5'b00011, INV = 5'b00100, ADD = 5'b00101,
                           SUB = 5'b00110, ANDO = 5'b00111, ORO = 5'b01000,
                           XORO = 5'b01001, SHL = 5'b01010, SHR = 5'b01011,
                           SAR = 5'b01100, UNDEF = 5'b11111;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  cmd;
    logic [63:0] a, b, flags;
    logic signed [63:0] out;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc, bad;

    fop_alu_seq #(.WIDTH(64), .SHAMT_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flags(flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [4:0] c, input logic [63:0] av, input logic [63:0] bv);
        in_valid = 1'b1;
        cmd      = c;
        a        = av;
        b        = bv;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from accept until out_valid; counts busy-cycle violations
    task automatic wait_valid(output int c, output int nbad);
        logic [63:0] out0;
        out0 = out;
        c    = 1;
        nbad = 0;
        while (!out_valid && c < 200) begin
            if (in_ready !== 1'b0 || out !== out0) nbad++;
            tick();
            c++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cmd = '0; a = '0; b = '0;
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_flags", flags, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        send(ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add_ovf_valid", 64'(out_valid), 64'd1);
        chk("add_ovf_out", out, 64'h8000_0000_0000_0000);
        chk("add_ovf_flags", flags, 64'h600);
        release_out();
        chk("add_idle_ready", 64'(in_ready), 64'd1);

        send(SUB, 64'd1, 64'd2);
        chk("sub_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sub_flags", flags, 64'h70200);
        release_out();
        send(PASSF, 64'd0, 64'd0);
        chk("passflag_out", out, 64'h70200);
        chk("passflag_flags", flags, 64'h70200);
        release_out();

        send(SAR, 64'h8000_0000_0000_0000, 64'd63);
        wait_valid(cyc, bad);
        chk("sar_latency", 64'(cyc), 64'd64);
        chk("sar_busy", 64'(bad), 64'd0);
        chk("sar_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sar_flags", flags, 64'h70200);
        release_out();

        send(SHL, 64'd1, 64'd0);
        chk("shl0_valid", 64'(out_valid), 64'd1);
        chk("shl0_out", out, 64'd1);
        chk("shl0_flags", flags, 64'h70200);
        release_out();

        send(SHR, 64'd3, 64'd1);
        wait_valid(cyc, bad);
        chk("shr1_latency", 64'(cyc), 64'd2);
        chk("shr1_out", out, 64'd1);
        chk("shr1_flags", flags, 64'h70100);
        release_out();

        send(SHL, 64'h1000_0000_0000_0000, 64'd4);
        wait_valid(cyc, bad);
        chk("shl4_latency", 64'(cyc), 64'd5);
        chk("shl4_busy", 64'(bad), 64'd0);
        chk("shl4_out", out, 64'd0);
        chk("shl4_flags", flags, 64'h70900);
        release_out();

        send(INV, 64'd0, 64'd0);
        chk("inv_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("inv_flags", flags, 64'h70300);
        release_out();

        send(XORO, 64'hF0, 64'hF0);
        chk("xor_out", out, 64'd0);
        chk("xor_flags", flags, 64'h70900);
        release_out();

        send(UNDEF, 64'd5, 64'd7);
        chk("undef_out", out, 64'd0);
        chk("undef_flags", flags, 64'h70900);
        release_out();

        send(SIGN, 64'd0, 64'h8000_0000_0000_0000);
        chk("sign_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sign_flags", flags, 64'h70300);
        release_out();

        // Backpressure: result held while a new command is offered
        send(ZERO, 64'd9, 64'd9);
        in_valid = 1'b1; cmd = ADD; a = 64'd1; b = 64'd1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 64'd0 || flags !== 64'h70900) bad++;
            tick();
        end
        chk("zero_hold", 64'(bad), 64'd0);
        release_out();
        chk("zero_release_valid", 64'(out_valid), 64'd0);
        chk("zero_release_ready", 64'(in_ready), 64'd1);
        chk("zero_no_same_cycle_accept", out, 64'd0);
        in_valid = 1'b0;

        // Reset in the middle of a long shift, with a command offered
        send(SHR, 64'hFFFF_0000_FFFF_0000, 64'd40);
        for (int k = 1; k < 10; k++) tick();
        rst = 1'b1; in_valid = 1'b1; cmd = LOADF; a = 64'hDEAD;
        #1;
        chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("rst_mid_out", out, 64'd0);
        chk("rst_mid_flags", flags, 64'd0);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_mid_ready_after", 64'(in_ready), 64'd1);
        tick();
        chk("rst_mid_stays_idle", 64'(out_valid), 64'd0);

        send(LOADF, 64'h1234, 64'd0);
        chk("loadflag_flags", flags, 64'h1234);
        chk("loadflag_out", out, 64'h1234);
        release_out();

        send(ORO, 64'd1, 64'd2);
        chk("or_out", out, 64'd3);
        chk("or_flags", flags, 64'h1034);
        release_out();

        send(ANDO, 64'hF, 64'h10);
        chk("and_out", out, 64'd0);
        chk("and_flags", flags, 64'h1834);
        release_out();

        send(ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add_carry_out", out, 64'd0);
        chk("add_carry_flags", flags, 64'h1934);
        release_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fop_alu_seq.md
FOP_ALU_SEQ -- requirements
Module: fop_alu_seq

Interface
REQ-001 Parameter WIDTH, default 64, datapath and flag-register width; legal values 32, 64 (flags use bits up to 18).
REQ-002 Parameter SHAMT_W, default 6, shift-amount width, SHALL equal log2(WIDTH).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  command offered.
REQ-006 in_ready  out  1  block can accept a command.
REQ-007 cmd  in  5  opcode.
REQ-008 a  in  WIDTH  operand A.
REQ-009 b  in  WIDTH  operand B / shift amount in b[SHAMT_W-1:0].
REQ-010 out_valid  out  1  result present on out.
REQ-011 out_ready  in  1  consumer takes result.
REQ-012 out  out  WIDTH  registered result, signed.
REQ-013 flags  out  WIDTH  live flag register F.

Function
REQ-014 F bits SHALL be C=8, N=9, V=10, Z=11, ULE=16, SLT=17, SLE=18; all other bits hold their value and change only via LOADFLAG.
REQ-015 The FSM SHALL have states IDLE, SHIFT, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL occur on a cycle with in_valid=1 and in_ready=1; a, b, cmd are captured at accept.
REQ-017 Single-cycle ops SHALL load out and update F at the accept edge and go to HOLD (out_valid=1 the next cycle, latency 1).
REQ-018 HOLD SHALL keep out and F stable until out_ready=1, then go to IDLE; out_valid and out_ready both 1 while in_valid is 1 SHALL NOT accept the new command in the same cycle (next accept no earlier than one cycle later).
REQ-019 ZERO 00000: out=0; N=0, Z=1.
REQ-020 SIGN 00001: out=all-ones if b[WIDTH-1] else 0; N=b[WIDTH-1], Z=~b[WIDTH-1].
REQ-021 PASSFLAG 00010: out=F; F unchanged.
REQ-022 LOADFLAG 00011: F=a and out=a.
REQ-023 INV 00100: out=~a; N=out MSB, Z=(out==0).
REQ-024 ADD 00101: out=a+b mod 2^WIDTH; C=carry out, V=signed overflow, N, Z.
REQ-025 SUB 00110: out=a-b mod 2^WIDTH; C=1 when no borrow (a>=b unsigned), V=signed overflow, N, Z, ULE=(a<=b unsigned), SLT=(a<b signed), SLE=(a<=b signed).
REQ-026 AND 00111 / OR 01000 / XOR 01001: bitwise; N, Z updated; C, V unchanged.
REQ-027 SHL 01010, SHR 01011 (zero fill), SAR 01100 (sign fill) SHALL be iterative: one bit per cycle in SHIFT, amount n=b[SHAMT_W-1:0].
REQ-028 Shift with n=0 SHALL behave as single-cycle: out=a, F unchanged, latency 1.
REQ-029 Shift with n>0 SHALL set out_valid exactly n+1 cycles after accept; C=last bit shifted out, N, Z from final result; V unchanged.
REQ-030 out SHALL not change while in SHIFT; out is written once at shift completion.
REQ-031 Undefined opcodes 01101-11111: out=0, F unchanged, latency 1.
REQ-032 Only the described flag bits SHALL change per opcode; F updates coincide with the edge that loads out.

Reset
REQ-033 rst=1 at a clock edge SHALL force state IDLE, out=0, F=0, out_valid=0, shift counter=0, overriding any in-progress shift or held result.
REQ-034 in_ready SHALL be 0 during a cycle with rst=1 and 1 on the first cycle after rst deasserts.
REQ-035 A command presented together with rst SHALL be dropped.

Verification
REQ-036 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> out=0x8000_0000_0000_0000, N=1, V=1, C=0, Z=0, out_valid one cycle after accept.
REQ-037 SUB a=1, b=2 -> out=0xFFFF_FFFF_FFFF_FFFF, C=0, ULE=1, SLT=1, SLE=1, N=1; then PASSFLAG -> out=F with bits 9,16,17,18 set.
REQ-038 SAR a=0x8000_0000_0000_0000, b=63 -> out_valid at cycle 64 after accept, out=all-ones, C=0, N=1; in_ready=0 throughout.
REQ-039 SHL a=1, b=0 -> out=1 after 1 cycle, F unchanged.
REQ-040 ZERO with out_ready held 0 for 5 cycles -> out_valid stays 1, out/F stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-041 rst asserted mid-SHR (b=40, cycle 10) -> next cycle out=0, F=0, out_valid=0, in_ready=1 once rst drops; LOADFLAG a=0x1234 -> flags=0x1234.
